// File: rtl/recip_pkg.sv
// Shared definitions for the recip result reader: FSM encoding, default
// field widths and the FIFO entry layout {zero_err, seq, fine, coarse}.
package recip_pkg;

   localparam int unsigned COARSE_WIDTH_DEF = 24;
   localparam int unsigned FINE_WIDTH_DEF   = 8;
   localparam int unsigned SEQ_WIDTH_DEF    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      DROP = 2'd2
   } recip_state_e;

   // Entry layout at default widths, MSB first.
   typedef struct packed {
      logic                        zero_err;
      logic [SEQ_WIDTH_DEF-1:0]    seq;
      logic [FINE_WIDTH_DEF-1:0]   fine;
      logic [COARSE_WIDTH_DEF-1:0] coarse;
   } recip_entry_t;

   function automatic int unsigned entry_width(input int unsigned cw,
                                               input int unsigned fw,
                                               input int unsigned sw);
      return 1 + sw + fw + cw;
   endfunction

endpackage

// File: rtl/recip_result_reader_if.sv
// Producer handshake and downstream stream of the recip result reader.
// master: environment side (producer + downstream); slave: the reader.
interface recip_result_reader_if import recip_pkg::*; #(
   parameter int unsigned COARSE_WIDTH = COARSE_WIDTH_DEF,
   parameter int unsigned FINE_WIDTH   = FINE_WIDTH_DEF,
   parameter int unsigned SEQ_WIDTH    = SEQ_WIDTH_DEF,
   parameter int unsigned FIFO_AW      = 2
) ();

   logic                    tdc_valid_fast;
   logic [COARSE_WIDTH-1:0] tdc_coarse_fast;
   logic [FINE_WIDTH-1:0]   tdc_fine_raw_fast;
   logic                    tdc_ack_fast;
   logic                    out_valid;
   logic                    out_ready;
   logic [COARSE_WIDTH-1:0] out_coarse;
   logic [FINE_WIDTH-1:0]   out_fine;
   logic [SEQ_WIDTH-1:0]    out_seq;
   logic                    out_zero_err;
   logic [FIFO_AW:0]        fifo_count;
   logic                    timeout_flag;

   modport master (
      output tdc_valid_fast, tdc_coarse_fast, tdc_fine_raw_fast, out_ready,
      input  tdc_ack_fast, out_valid, out_coarse, out_fine, out_seq,
             out_zero_err, fifo_count, timeout_flag
   );

   modport slave (
      input  tdc_valid_fast, tdc_coarse_fast, tdc_fine_raw_fast, out_ready,
      output tdc_ack_fast, out_valid, out_coarse, out_fine, out_seq,
             out_zero_err, fifo_count, timeout_flag
   );

endinterface

// File: rtl/recip_result_fifo.sv
// Synchronous FIFO with registered occupancy count, depth 2^AW.
// Pushes when full and pops when empty are ignored.
module recip_result_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 2
) (
   input  logic             clk_fast,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage; cleared on reset so the head reads as zero after reset.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/recip_result_reader.sv
// Consumer of the recip_core_fast result handshake: captures each result,
// acks it for one cycle, tags it with a wrapping sequence number and queues
// it for a valid/ready stream. Backpressure = ack withheld while FIFO full.
// Optional idle timeout built when RECIP_READER_TIMEOUT_EN is defined.
module recip_result_reader import recip_pkg::*; #(
   parameter int unsigned COARSE_WIDTH   = COARSE_WIDTH_DEF,
   parameter int unsigned FINE_WIDTH     = FINE_WIDTH_DEF,
   parameter int unsigned SEQ_WIDTH      = SEQ_WIDTH_DEF,
   parameter int unsigned FIFO_AW        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input logic                   clk_fast,
   input logic                   rst_n,
   recip_result_reader_if.slave  bus
);

   localparam int unsigned ENTRY_W = entry_width(COARSE_WIDTH, FINE_WIDTH, SEQ_WIDTH);

   recip_state_e         state;
   recip_state_e         state_nx;
   logic [SEQ_WIDTH-1:0] seq;
   logic                 ack_q;
   logic                 capture;
   logic                 full;
   logic                 empty;
   logic                 pop;
   logic [ENTRY_W-1:0]   wr_data;
   logic [ENTRY_W-1:0]   rd_data;

   // Next state: capture only from IDLE with room, then ack, then wait for valid low.
   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.tdc_valid_fast && !full) begin
               capture  = 1'b1;
               state_nx = ACK;
            end
         end
         ACK:     state_nx = DROP;
         DROP:    if (!bus.tdc_valid_fast) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, registered ack and sequence tag.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ack_q <= 1'b0;
         seq   <= '0;
      end else begin
         state <= state_nx;
         ack_q <= (state_nx == ACK);
         if (capture) seq <= seq + 1'b1;
      end
   end

   assign wr_data = {(bus.tdc_coarse_fast == '0), seq,
                     bus.tdc_fine_raw_fast, bus.tdc_coarse_fast};
   assign pop     = !empty && bus.out_ready;

   recip_result_fifo #(
      .WIDTH (ENTRY_W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk_fast (clk_fast),
      .rst_n    (rst_n),
      .push     (capture),
      .wr_data  (wr_data),
      .pop      (pop),
      .rd_data  (rd_data),
      .count    (bus.fifo_count),
      .full     (full),
      .empty    (empty)
   );

   assign bus.tdc_ack_fast = ack_q;
   assign bus.out_valid    = !empty;
   assign bus.out_coarse   = rd_data[COARSE_WIDTH-1:0];
   assign bus.out_fine     = rd_data[COARSE_WIDTH +: FINE_WIDTH];
   assign bus.out_seq      = rd_data[COARSE_WIDTH+FINE_WIDTH +: SEQ_WIDTH];
   assign bus.out_zero_err = rd_data[ENTRY_W-1];

`ifdef RECIP_READER_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] idle_cnt;

   // Idle counter: cleared by a capture, saturates at TIMEOUT_CYCLES-1.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n)                    idle_cnt <= '0;
      else if (capture)              idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
   end

   assign bus.timeout_flag = (idle_cnt == IDLE_MAX);
`else
   // No timeout hardware; the parameter stays so override lists are uniform.
   assign bus.timeout_flag = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_recip_result_reader.sv
// Scoreboard bench for recip_result_reader: expected entries are queued when
// a result is offered; a monitor pops and compares on every stream handshake.
module tb_recip_result_reader;

   localparam int unsigned CW = 24;
   localparam int unsigned FW = 8;
   localparam int unsigned SW = 8;
   localparam int unsigned AW = 2;

   logic clk_fast = 1'b0;
   logic rst_n    = 1'b0;

   always #5 clk_fast = ~clk_fast;

   recip_result_reader_if #(
      .COARSE_WIDTH (CW),
      .FINE_WIDTH   (FW),
      .SEQ_WIDTH    (SW),
      .FIFO_AW      (AW)
   ) bus ();

   recip_result_reader #(
      .COARSE_WIDTH   (CW),
      .FINE_WIDTH     (FW),
      .SEQ_WIDTH      (SW),
      .FIFO_AW        (AW),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk_fast (clk_fast),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   typedef struct packed {
      logic          z;
      logic [SW-1:0] s;
      logic [FW-1:0] f;
      logic [CW-1:0] c;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [SW-1:0] exp_seq = '0;
   logic [SW-1:0] last_seq = '0;
   logic          last_zero = 1'b0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor: every accepted head must match the oldest expected entry.
   always @(negedge clk_fast) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop actual_seq=0x%0h required=none", bus.out_seq);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pop_coarse", 32'(bus.out_coarse), 32'(mon_e.c));
            chk("pop_fine", 32'(bus.out_fine), 32'(mon_e.f));
            chk("pop_seq", 32'(bus.out_seq), 32'(mon_e.s));
            chk("pop_zero_err", 32'(bus.out_zero_err), 32'(mon_e.z));
            last_seq  = bus.out_seq;
            last_zero = bus.out_zero_err;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk_fast); #1;
      rst_n = 1'b0;
      bus.tdc_valid_fast = 1'b0;
      exp_q.delete();
      exp_seq = '0;
      repeat (2) @(posedge clk_fast);
      #1 rst_n = 1'b1;
   endtask

   task automatic offer(input logic [CW-1:0] c, input logic [FW-1:0] f);
      exp_t e;
      @(posedge clk_fast); #1;
      bus.tdc_valid_fast    = 1'b1;
      bus.tdc_coarse_fast   = c;
      bus.tdc_fine_raw_fast = f;
      e.z = (c == '0);
      e.s = exp_seq;
      e.f = f;
      e.c = c;
      exp_q.push_back(e);
      exp_seq = exp_seq + 1'b1;
   endtask

   task automatic wait_ack(input string name, input int maxcyc);
      bit seen = 1'b0;
      for (int i = 0; i < maxcyc && !seen; i++) begin
         @(negedge clk_fast);
         if (bus.tdc_ack_fast) seen = 1'b1;
      end
      chk({name, "_ack_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         @(negedge clk_fast);
         chk({name, "_ack_width"}, 32'(bus.tdc_ack_fast), 32'd0);
      end
   endtask

   task automatic release_valid(input int hold);
      repeat (hold) @(posedge clk_fast);
      @(posedge clk_fast); #1;
      bus.tdc_valid_fast = 1'b0;
   endtask

   task automatic send(input logic [CW-1:0] c, input logic [FW-1:0] f,
                       input int hold, input string name);
      offer(c, f);
      wait_ack(name, 8);
      release_valid(hold);
   endtask

   task automatic drain(input string name, input int maxcyc);
      bit done = 1'b0;
      @(posedge clk_fast); #1 bus.out_ready = 1'b1;
      for (int i = 0; i < maxcyc && !done; i++) begin
         @(negedge clk_fast);
         if (bus.fifo_count == '0 && exp_q.size() == 0) done = 1'b1;
      end
      chk({name, "_drained"}, 32'(done), 32'd1);
      @(posedge clk_fast); #1 bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.tdc_valid_fast    = 1'b0;
      bus.tdc_coarse_fast   = '0;
      bus.tdc_fine_raw_fast = '0;
      bus.out_ready         = 1'b0;
      rst_n                 = 1'b0;

      // Reset values
      repeat (2) @(negedge clk_fast);
      chk("rst_ack", 32'(bus.tdc_ack_fast), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_coarse", 32'(bus.out_coarse), 32'd0);
      chk("rst_out_fine", 32'(bus.out_fine), 32'd0);
      chk("rst_out_seq", 32'(bus.out_seq), 32'd0);
      chk("rst_out_zero_err", 32'(bus.out_zero_err), 32'd0);
      chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
      chk("rst_timeout", 32'(bus.timeout_flag), 32'd0);
      @(posedge clk_fast); #1 rst_n = 1'b1;

      // Single result held until ack
      send(24'h000C35, 8'h8F, 0, "single");
      @(negedge clk_fast);
      chk("single_out_valid", 32'(bus.out_valid), 32'd1);
      chk("single_count", 32'(bus.fifo_count), 32'd1);
      chk("single_coarse", 32'(bus.out_coarse), 32'h000C35);
      chk("single_fine", 32'(bus.out_fine), 32'h8F);
      chk("single_seq", 32'(bus.out_seq), 32'd0);
      chk("single_zero_err", 32'(bus.out_zero_err), 32'd0);
      drain("single", 10);

      // Valid held 4 cycles past ack: one capture only
      send(24'h0001F4, 8'h12, 4, "late");
      repeat (4) @(negedge clk_fast);
      chk("late_count", 32'(bus.fifo_count), 32'd1);
      chk("late_seq", 32'(bus.out_seq), 32'd1);
      drain("late", 10);

      // Backpressure: four fill the FIFO, the fifth stalls until one pop
      do_reset();
      for (int i = 0; i < 4; i++) send(24'h000100 + CW'(i), 8'h20 + FW'(i), 0, "bp");
      repeat (3) @(negedge clk_fast);
      chk("bp_full_count", 32'(bus.fifo_count), 32'd4);
      offer(24'h000104, 8'h24);
      begin
         bit stalled_ack = 1'b0;
         repeat (6) begin
            @(negedge clk_fast);
            if (bus.tdc_ack_fast) stalled_ack = 1'b1;
         end
         chk("bp_stall_no_ack", 32'(stalled_ack), 32'd0);
      end
      chk("bp_stall_count", 32'(bus.fifo_count), 32'd4);
      @(posedge clk_fast); #1 bus.out_ready = 1'b1;
      @(posedge clk_fast); #1 bus.out_ready = 1'b0;
      @(negedge clk_fast);
      chk("bp_pop_no_same_cycle_ack", 32'(bus.tdc_ack_fast), 32'd0);
      chk("bp_pop_count", 32'(bus.fifo_count), 32'd3);
      wait_ack("bp5", 3);
      chk("bp5_count", 32'(bus.fifo_count), 32'd4);
      release_valid(0);
      drain("bp", 20);
      chk("bp_last_seq", 32'(last_seq), 32'd4);

      // 257 results with ready high; last has coarse 0
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 257; i++)
         send((i == 256) ? 24'h0 : 24'h001000 + CW'(i), FW'(i), 0, "wrap");
      drain("wrap", 10);
      chk("wrap_last_seq", 32'(last_seq), 32'd0);
      chk("wrap_last_zero", 32'(last_zero), 32'd1);

`ifdef RECIP_READER_TIMEOUT_EN
      // Idle timeout at cycle 99, cleared by the next capture
      do_reset();
      repeat (98) @(posedge clk_fast);
      #1 chk("to_before", 32'(bus.timeout_flag), 32'd0);
      @(posedge clk_fast);
      #1 chk("to_set", 32'(bus.timeout_flag), 32'd1);
      repeat (20) @(posedge clk_fast);
      #1 chk("to_hold", 32'(bus.timeout_flag), 32'd1);
      offer(24'h000321, 8'h03);
      wait_ack("to_cap", 8);
      chk("to_cleared", 32'(bus.timeout_flag), 32'd0);
      release_valid(0);
      drain("to", 10);
`else
      repeat (120) @(posedge clk_fast);
      #1 chk("to_tied_low", 32'(bus.timeout_flag), 32'd0);
`endif

      // Reset asserted while ack is high
      do_reset();
      offer(24'h00ABCD, 8'h55);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk_fast);
            if (bus.tdc_ack_fast) seen = 1'b1;
         end
         chk("mid_ack_seen", 32'(seen), 32'd1);
      end
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(bus.tdc_ack_fast), 32'd0);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
      bus.tdc_valid_fast = 1'b0;
      exp_q.delete();
      exp_seq = '0;
      repeat (2) @(posedge clk_fast);
      #1 rst_n = 1'b1;
      send(24'h000777, 8'h77, 0, "post_rst");
      @(negedge clk_fast);
      chk("post_rst_count", 32'(bus.fifo_count), 32'd1);
      chk("post_rst_seq", 32'(bus.out_seq), 32'd0);
      drain("post_rst", 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500_000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
